// File: rtl/pipeline_stall_ctrl.sv
`default_nettype none
// ============================================================================
// pipeline_stall_ctrl: merges IF/ID/EX stall and flush requests into stop_all,
// sequences multi-cycle EX ops and counts stall cycles (saturating).
// Revision: 1.0
// ============================================================================
module pipeline_stall_ctrl #(
  parameter int EX_CYCLE_WIDTH = 6,
  parameter int PERF_WIDTH     = 32
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      stop_request_from_if,
  input  logic                      stop_request_from_id,
  input  logic                      stop_request_from_ex,
  input  logic                      ex_start,
  input  logic [EX_CYCLE_WIDTH-1:0] ex_cycles,
  input  logic                      flush_request,
  output logic [5:0]                stop_all,
  output logic                      flush,
  output logic                      ex_op_done,
  output logic                      ex_busy,
  output logic [PERF_WIDTH-1:0]     stall_cycle_count
);

  typedef enum logic [0:0] {
    S_IDLE    = 1'b0,
    S_EX_BUSY = 1'b1
  } state_t;

  localparam logic [5:0] c_stop_ex   = 6'b001111;
  localparam logic [5:0] c_stop_id   = 6'b000111;
  localparam logic [5:0] c_stop_if   = 6'b000011;
  localparam logic [EX_CYCLE_WIDTH-1:0] c_one = EX_CYCLE_WIDTH'(1);

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [EX_CYCLE_WIDTH-1:0] r_remaining;
  logic [EX_CYCLE_WIDTH-1:0] w_remaining_nxt;
  logic [PERF_WIDTH-1:0]     r_stall_cycle_count;
  logic                      w_start;
  logic                      w_ex_stall;

  assign w_start    = (r_state == S_IDLE) && ex_start;
  assign w_ex_stall = (r_state == S_EX_BUSY) || (w_start && (ex_cycles != '0))
                      || stop_request_from_ex;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_remaining <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_remaining <= w_remaining_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_remaining_nxt = r_remaining;
    stop_all        = 6'b000000;
    flush           = 1'b0;
    ex_op_done      = 1'b0;
    ex_busy         = (r_state == S_EX_BUSY);

    if (flush_request) begin
      // Flush aborts any sequenced op silently.
      flush           = 1'b1;
      w_state_nxt     = S_IDLE;
      w_remaining_nxt = '0;
    end else begin
      if (w_ex_stall)                stop_all = c_stop_ex;
      else if (stop_request_from_id) stop_all = c_stop_id;
      else if (stop_request_from_if) stop_all = c_stop_if;

      if (r_state == S_EX_BUSY) begin
        if (r_remaining <= c_one) begin
          ex_op_done      = (r_remaining == c_one);
          w_state_nxt     = S_IDLE;
          w_remaining_nxt = '0;
        end else begin
          w_remaining_nxt = r_remaining - c_one;
        end
      end else if (w_start) begin
        if (ex_cycles <= c_one) begin
          ex_op_done = 1'b1;
        end else begin
          w_state_nxt     = S_EX_BUSY;
          w_remaining_nxt = ex_cycles - c_one;
        end
      end
    end

    if (!reset) begin
      stop_all   = 6'b000000;
      flush      = 1'b0;
      ex_op_done = 1'b0;
      ex_busy    = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_stall_cycle_count <= '0;
    end else if (stop_all[0] && (r_stall_cycle_count != '1)) begin
      r_stall_cycle_count <= r_stall_cycle_count + PERF_WIDTH'(1);
    end
  end

  assign stall_cycle_count = r_stall_cycle_count;

endmodule
`default_nettype wire

// File: doc/pipeline_stall_ctrl.md
# pipeline_stall_ctrl

Central stall/flush controller for the five-stage pipeline. It merges stall requests from IF, ID and EX plus a flush request into the `stop_all` bus consumed by the pc, if_id, id_ex, ex_mem and mem_wb registers. It owns the cycle sequencing of multi-cycle EX operations (load count, hold pipeline, signal completion), so EX units only issue a start pulse with a cycle count. It also keeps a saturating stall-cycle performance counter.

## Interface
- `EX_CYCLE_WIDTH`, default 6: width of the multi-cycle length field and the internal down-counter.
- `PERF_WIDTH`, default 32: width of the stall-cycle counter.

- `clock`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  reset is synchronous and active-low. It is sampled on the rising edge of `clock`, and `reset`=0 resets the block.
- `stop_request_from_if`  in  1  fetch not ready; level.
- `stop_request_from_id`  in  1  load-use hazard; level.
- `stop_request_from_ex`  in  1  external EX unit not ready; level.
- `ex_start`  in  1  one-cycle pulse that starts a sequenced multi-cycle EX op.
- `ex_cycles`  in  EX_CYCLE_WIDTH  total stall cycles for the op, including the start cycle. Sampled with `ex_start`.
- `flush_request`  in  1  exception/redirect flush; pulse.
- `stop_all`  out  6  per-stage stop: bit0 pc, bit1 if, bit2 id, bit3 ex, bit4 mem, bit5 wb. 1 = stop.
- `flush`  out  1  clear all pipeline registers this cycle.
- `ex_op_done`  out  1  one-cycle pulse marking the final cycle of a sequenced op.
- `ex_busy`  out  1  high while in EX_BUSY.
- `stall_cycle_count`  out  PERF_WIDTH  cycles with `stop_all[0]`=1, saturating.

## Operation
- FSM states: IDLE, EX_BUSY. Registers: `state`, `remaining` (EX_CYCLE_WIDTH), `stall_cycle_count`.
- `stop_all`, `flush`, `ex_op_done` and `ex_busy` are combinational from the registered state and current inputs. Pipeline registers must see the stall in the same cycle as the request.
- Stall patterns: EX stall = 6'b001111; ID stall = 6'b000111 (id_ex inserts a bubble); IF stall = 6'b000011; none = 6'b000000.
- Priority, highest first:
  1. `flush_request`: `flush`=1, `stop_all`=0. Any sequenced op is aborted (state→IDLE, `remaining`→0, no `ex_op_done`).
  2. EX stall, if any of these hold: state=EX_BUSY; or IDLE with `ex_start`=1 and `ex_cycles`≥1; or `stop_request_from_ex`=1.
  3. ID stall.
  4. IF stall.
- IDLE with `ex_start`=1:
  - `ex_cycles`=N≥2: this cycle stalls. Load `remaining`=N−1, go to EX_BUSY.
  - N=1: stall this cycle, `ex_op_done`=1 this cycle, stay IDLE.
  - N=0: no stall from the op, `ex_op_done`=1 this cycle, stay IDLE.
- EX_BUSY: stall every cycle and decrement `remaining`. When `remaining`=1, `ex_op_done`=1 in that cycle, then go to IDLE.
- `ex_start` while in EX_BUSY is ignored (protocol violation; no state change).
- `stop_request_from_ex` does not affect `remaining`. It only ORs into the EX stall and can extend a stall past `ex_op_done`.
- Perf counter:
  - increments by 1 on each edge where `stop_all[0]`=1;
  - holds at all-ones;
  - flush cycles are not counted.

## Timing
- Reset (`reset`=0 at an edge): state=IDLE, `remaining`=0, `stall_cycle_count`=0.
  - While `reset`=0, outputs are forced to `stop_all`=0, `flush`=0, `ex_op_done`=0, `ex_busy`=0, regardless of inputs.
  - Reset mid-op aborts the op with no `ex_op_done`.
- Stall/flush latency: 0 cycles (same-cycle combinational response to requests).
- Sequenced op with N≥1: exactly N consecutive cycles with `stop_all`=6'b001111, starting in the `ex_start` cycle. `ex_op_done` is high in the Nth. The first non-stalled cycle is N cycles after start, unless other requests are active.
- `ex_busy`: 1 for cycles 2..N of the op.
- A flush in the same cycle as `ex_start` wins; the op is never started.
- `remaining` never wraps; the decrement happens only in EX_BUSY with `remaining`≥1.

## Test plan
- Reset: hold `reset`=0 for 3 cycles with all requests high → `stop_all`=0, `flush`=0, `stall_cycle_count`=0. After release with no requests → `stop_all`=0.
- Priority: `stop_request_from_if`=1 and `stop_request_from_id`=1 → `stop_all`=6'b000111. Add `stop_request_from_ex`=1 → 6'b001111. Add `flush_request`=1 → `stop_all`=0, `flush`=1.
- Sequenced op: `ex_start`, `ex_cycles`=5 → `stop_all`=6'b001111 for exactly 5 cycles. `ex_op_done` only in the 5th. `ex_busy` in cycles 2–5. `stall_cycle_count` rises by 5.
- Edge lengths: `ex_cycles`=1 → 1 stall cycle with `ex_op_done` in the same cycle. `ex_cycles`=0 → no stall, `ex_op_done`=1 that cycle.
- Abort: `ex_cycles`=10, `flush_request` in cycle 4 → that cycle `flush`=1, `stop_all`=0. Next cycle IDLE, no stall, `ex_op_done` never asserted. Also check `reset`=0 in cycle 4 gives the same abort.
- Saturation and ignore:
  - Preload the perf counter near max (PERF_WIDTH=4, 13 stall cycles) → the counter reaches 15 and holds.
  - Pulse `ex_start` with `ex_cycles`=9 during EX_BUSY → the original op's length is unchanged.
